// File: rtl/data_memory_lsu.sv
// data_memory_lsu: single-port data RAM with RV32I load/store sizing.
//
// Accepts one request per cycle. Stores commit on the request's clock edge using byte-lane
// enables. Loads are read at the request edge and presented, sized and extended, one cycle
// later. Faulting requests never touch the array; they produce an error pulse one cycle later.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears response outputs, not the array)
//   req_valid  request present this cycle
//   req_we     1 = store, 0 = load
//   funct3     RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr       byte address
//   wdata      store data, right-aligned
//   rsp_valid  load data valid, one cycle after an accepted load
//   rdata      sized, extended load result (zero when rsp_valid is low)
//   err_valid  fault pulse, one cycle after a faulting request
//   err_code   01 misaligned, 10 out of range, 11 illegal funct3, 00 otherwise
module data_memory_lsu #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned INIT_MODE   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    assign word_idx = addr[ADDR_W-1:2];
    assign offset   = addr[1:0];

    // Fault classification, highest priority first.
    logic       illegal, misaligned, out_of_range;
    logic [1:0] fault_code;
    logic       fault, store_ok, load_ok;

    always_comb begin
        illegal      = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                       (req_we && funct3[2]);
        misaligned   = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3 == 3'b010) && (offset != 2'b00));
        out_of_range = 64'(word_idx) >= 64'(DEPTH_WORDS);
        if (illegal)           fault_code = 2'b11;
        else if (misaligned)   fault_code = 2'b01;
        else if (out_of_range) fault_code = 2'b10;
        else                   fault_code = 2'b00;
        fault    = req_valid && (fault_code != 2'b00);
        store_ok = req_valid && req_we && (fault_code == 2'b00);
        load_ok  = req_valid && !req_we && (fault_code == 2'b00);
    end

    // Store lane enables and data replicated across lanes so the enable alone picks the target.
    logic [3:0]  byte_en;
    logic [31:0] lane_data;

    always_comb begin
        unique case (funct3[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = 4'b0011 << offset;
                lane_data = {2{wdata[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wdata;
            end
        endcase
    end

    // Array: one register per word so each can carry its power-up value without a reset.
    logic [31:0] word_rd [DEPTH_WORDS];

    for (genvar i = 0; i < DEPTH_WORDS; i++) begin : g_word
        logic [31:0] word_q = (INIT_MODE == 1) ? 32'(i) : 32'd0;
        logic        sel;

        assign sel = store_ok && (64'(word_idx) == 64'(i));

        always_ff @(posedge clk) begin
            if (sel) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) word_q[8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end

        assign word_rd[i] = word_q;
    end

    // Read mux and load extraction.
    logic [31:0] rd_word, shift_b, shift_h, load_data;

    always_comb begin
        rd_word = 32'd0;
        for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
            if (64'(word_idx) == 64'(i)) rd_word = word_rd[i];
        end
        shift_b = rd_word >> {offset, 3'b000};
        shift_h = rd_word >> {offset[1], 4'b0000};
        unique case (funct3)
            3'b000:  load_data = {{24{shift_b[7]}}, shift_b[7:0]};
            3'b100:  load_data = {24'd0, shift_b[7:0]};
            3'b001:  load_data = {{16{shift_h[15]}}, shift_h[15:0]};
            3'b101:  load_data = {16'd0, shift_h[15:0]};
            default: load_data = rd_word;
        endcase
    end

    // Response registers; outputs are zeroed whenever they are not valid.
    logic        rsp_valid_q, err_valid_q;
    logic [31:0] rdata_q;
    logic [1:0]  err_code_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_valid_q <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            rsp_valid_q <= load_ok;
            rdata_q     <= load_ok ? load_data : 32'd0;
            err_valid_q <= fault;
            err_code_q  <= fault ? fault_code : 2'b00;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu: the driver pushes the reference model's expected
// response for every cycle it drives; the monitor pops and compares one cycle later.
module tb_data_memory_lsu;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err_valid;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    data_memory_lsu #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_W     (32),
        .INIT_MODE  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_we   (req_we),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rsp_valid(rsp_valid),
        .rdata    (rdata),
        .err_valid(err_valid),
        .err_code (err_code)
    );

    typedef struct {
        string       name;
        logic        rsp;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model[DEPTH];

    // Reference model: byte-addressed view of memory with RV32I sizing rules.
    function automatic exp_t ref_access(input string nm, input logic we, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int unsigned size, off, idx;
        logic        ill, mis, oor;
        logic [31:0] v;
        e.name  = nm;
        e.rsp   = 1'b0;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.code  = 2'b00;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = a % 4;
        idx  = a / 4;
        ill  = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3[2]);
        mis  = (a % size) != 0;
        oor  = idx >= DEPTH;
        if (ill || mis || oor) begin
            e.err  = 1'b1;
            e.code = ill ? 2'b11 : mis ? 2'b01 : 2'b10;
        end else if (we) begin
            for (int k = 0; k < int'(size); k++) model[idx][8*(int'(off)+k) +: 8] = wd[8*k +: 8];
        end else begin
            v = model[idx] >> (8 * off);
            if (size == 1) begin
                v = v & 32'h0000_00FF;
                if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'h0000_FFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            e.rsp   = 1'b1;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        sb.push_back(ref_access(nm, we, f3, a, wd));
    endtask

    task automatic idle(input string nm);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        funct3    = 3'($urandom_range(0, 7));
        addr      = $urandom;
        e.name  = nm;
        e.rsp   = 1'b0;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.code  = 2'b00;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string nm);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rdata !== 32'd0 || err_valid !== 1'b0 || err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL %s: got rsp=%b rdata=%h err=%b code=%b, want all zero",
                     nm, rsp_valid, rdata, err_valid, err_code);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest expectation after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (rsp_valid !== e.rsp || rdata !== e.rdata ||
                    err_valid !== e.err || err_code !== e.code) begin
                    n_bad++;
                    $display("FAIL %s: got rsp=%b rdata=%h err=%b code=%b, want rsp=%b rdata=%h err=%b code=%b",
                             e.name, rsp_valid, rdata, err_valid, err_code,
                             e.rsp, e.rdata, e.err, e.code);
                end
            end else if (rst_n && (rsp_valid || err_valid)) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got rsp=%b err=%b, want none", rsp_valid, err_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] f3;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);

        #3;
        check_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic and back-to-back loads.
        issue("lw_04", 1'b0, 3'b010, 32'h04, 32'd0);
        issue("lw_08", 1'b0, 3'b010, 32'h08, 32'd0);
        issue("lw_0c", 1'b0, 3'b010, 32'h0C, 32'd0);
        // Byte store and sized loads.
        issue("sb_09", 1'b1, 3'b000, 32'h09, 32'h1234_56AB);
        issue("lw_08_after_sb", 1'b0, 3'b010, 32'h08, 32'd0);
        issue("lb_09", 1'b0, 3'b000, 32'h09, 32'd0);
        issue("lbu_09", 1'b0, 3'b100, 32'h09, 32'd0);
        // Half store and sized loads.
        issue("sh_12", 1'b1, 3'b001, 32'h12, 32'h0000_F00D);
        issue("lw_10_after_sh", 1'b0, 3'b010, 32'h10, 32'd0);
        issue("lh_12", 1'b0, 3'b001, 32'h12, 32'd0);
        issue("lhu_12", 1'b0, 3'b101, 32'h12, 32'd0);
        // Faults and memory preservation.
        issue("lh_03_misaligned", 1'b0, 3'b001, 32'h03, 32'd0);
        issue("sw_06_misaligned", 1'b1, 3'b010, 32'h06, 32'hDEAD_BEEF);
        issue("lw_04_after_fault", 1'b0, 3'b010, 32'h04, 32'd0);
        issue("lw_100_range", 1'b0, 3'b010, 32'h100, 32'd0);
        issue("sw_100_range", 1'b1, 3'b010, 32'h100, 32'hCAFE_F00D);
        issue("f3_011_illegal", 1'b0, 3'b011, 32'h00, 32'd0);
        issue("sbu_illegal", 1'b1, 3'b100, 32'h20, 32'hFFFF_FFFF);
        issue("lw_20_after_illegal", 1'b0, 3'b010, 32'h20, 32'd0);
        issue("lw_fc_last", 1'b0, 3'b010, 32'hFC, 32'd0);
        // Idle after a load.
        issue("lw_04_pre_idle", 1'b0, 3'b010, 32'h04, 32'd0);
        idle("idle_1");
        idle("idle_2");
        idle("idle_3");

        // Reset with a load pending; the preceding load leaves rsp_valid high.
        issue("lw_0c_pre_reset", 1'b0, 3'b010, 32'h0C, 32'd0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h04;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        sb.delete();
        req_valid = 1'b0;
        @(negedge clk);
        check_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        issue("lw_08_after_reset", 1'b0, 3'b010, 32'h08, 32'd0);

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle("rand_idle");
            end else begin
                if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
                else begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end
                issue("rand", 1'($urandom_range(0, 1)), f3,
                      32'($urandom_range(0, 4 * DEPTH + 31)), $urandom);
            end
        end

        // Sweep every word so any corrupted location is seen.
        for (int i = 0; i < DEPTH; i++) issue("sweep_lw", 1'b0, 3'b010, 32'(4 * i), 32'd0);
        idle("drain_1");
        idle("drain_2");
        @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Parametrised successor to the core's word-only data memory.
- Single-port data RAM with full RV32I load/store sizing (byte/half/word, signed/unsigned) and byte-lane write enables.
- Registered read path with a 1-cycle valid handshake; misalignment and out-of-range detection.
- Sits between the execute/MEM stage and the data array; the MEM stage consumes rsp_valid/rdata for writeback.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (need not be a power of two, >=1).
- ADDR_W, 32, width of the byte address input.
- INIT_MODE, 1, power-up array contents: 0 = all zero, 1 = mem[i] = i.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present this cycle (one request per cycle, always accepted)
- req_we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal
- addr  input  ADDR_W  byte address
- wdata  input  32  store data, right-aligned (low bits used for B/H)
- rsp_valid  output  1  load data valid (pulse, 1 cycle after accepted load)
- rdata  output  32  sized, extended load result
- err_valid  output  1  fault pulse, 1 cycle after a faulting request (load or store)
- err_code  output  2  01 misaligned, 10 out of range, 11 illegal funct3; 00 when no fault

Behaviour:
- Reset (rst_n low, async): rsp_valid=0, rdata=0, err_valid=0, err_code=0.
  - Array contents are NOT reset; they hold the INIT_MODE preload or the last written data.
  - Reset mid-operation discards any pending response.
- Word index = addr[ADDR_W-1:2]; byte offset = addr[1:0].
- Fault checks, evaluated on each accepted request, priority high to low:
  - Illegal funct3: 011, 110, 111, or any store with funct3[2]=1.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Out of range: word index >= DEPTH_WORDS.
- Faulting request: no array write. Next cycle err_valid=1, err_code set, rsp_valid=0, rdata=0.
- Store (no fault): write at posedge using byte lanes.
  - SB: lane = offset, data wdata[7:0].
  - SH: lanes offset and offset+1, data wdata[15:0].
  - SW: all four lanes.
  - Unwritten lanes are preserved.
  - No response pulse: rsp_valid stays 0, err_valid stays 0.
- Load (no fault): array read sampled at the request posedge.
  - Next cycle rsp_valid=1, rdata = selected lane(s) shifted to bit 0.
  - B/H: sign-extended. BU/HU: zero-extended. W: unchanged.
- Latency: exactly 1 cycle from accepted load to rsp_valid. Throughput: 1 request per cycle. Back-to-back loads give back-to-back rsp_valid.
- Store followed by load on the next cycle to the same word returns the new data, since the write commits at the store's edge.
- req_valid=0: next cycle rsp_valid=0, err_valid=0, rdata=0, err_code=0. Outputs are zeroed whenever they are not valid.
- Byte lanes are little-endian: lane 0 = bits [7:0].

Test Plan:
- INIT_MODE=1, DEPTH 64: LW addr 0x04 -> next cycle rsp_valid=1, rdata=0x00000001. Back-to-back LW 0x08, 0x0C -> rdata 0x2, then 0x3 on consecutive cycles.
- SB addr 0x09, wdata 0x123456AB, then LW 0x08 -> rdata 0x0000AB02. Then LB 0x09 -> 0xFFFFFFAB; LBU 0x09 -> 0x000000AB.
- SH addr 0x12, wdata 0x0000F00D, then LW 0x10 -> 0xF00D0004. LH 0x12 -> 0xFFFFF00D; LHU 0x12 -> 0x0000F00D.
- Faults, each with memory unchanged afterwards:
  - LH 0x03 -> err_valid=1, err_code=01, rsp_valid=0.
  - SW 0x06 -> err_code=01, and LW 0x04 still returns 0x1.
  - LW 0x100 -> err_code=10.
  - funct3=011 -> err_code=11.
- Reset: issue LW 0x04, assert rst_n low before the next edge -> rsp_valid=0, rdata=0 immediately. After release, LW 0x08 returns the SB-modified 0x0000AB02 (array retained).
- Idle: req_valid=0 for 3 cycles after a load -> rsp_valid, err_valid, rdata, err_code all 0 on each of those cycles.
